// File: rtl/pattern_pkg.sv
// ============================================================================
// pattern_pkg : shared constants and state encoding for the pattern stream
//               generator (pattern value, filler symbols, LFSR seed).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pattern_pkg;

    localparam int         PAT_LEN   = 6;
    localparam logic [5:0] PATTERN   = 6'b001101;
    localparam logic       B         = 1'b0;
    localparam logic       C         = 1'b1;
    localparam logic [6:0] LFSR_SEED = 7'h5A;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_PAT  = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_FIN  = 4'b1000
    } state_e;

    // Index 0 is the first bit on the wire, i.e. the MSB of PATTERN.
    function automatic logic pat_bit(input logic [2:0] idx);
        return PATTERN[3'(PAT_LEN - 1) - idx];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_stream_gen_if.sv
// ============================================================================
// pattern_stream_gen_if : burst control and valid/ready serial stream bundle
//                         between the pattern generator and its user.
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface pattern_stream_gen_if #(
    parameter int FRAMES_W = 8,
    parameter int GAP_W    = 4
);
    logic                start_i;
    logic [FRAMES_W-1:0] num_frames_i;
    logic [GAP_W-1:0]    gap_i;
    logic                ready_i;
    logic                valid_o;
    logic                data_o;
    logic                busy_o;
    logic                done_o;
    logic [FRAMES_W-1:0] sent_count_o;

    modport slave (
        input  start_i, num_frames_i, gap_i, ready_i,
        output valid_o, data_o, busy_o, done_o, sent_count_o
    );

    modport master (
        output start_i, num_frames_i, gap_i, ready_i,
        input  valid_o, data_o, busy_o, done_o, sent_count_o
    );
endinterface

`default_nettype wire

// File: rtl/pattern_lfsr.sv
// ============================================================================
// pattern_lfsr : 7-bit maximal Fibonacci LFSR (x^7+x^6+1) used as filler
//                source. Exists only when PATTERN_GEN_LFSR_FILLER_EN is set.
// Revision     : 1.0
// ============================================================================
`default_nettype none

`ifdef PATTERN_GEN_LFSR_FILLER_EN
module pattern_lfsr
    import pattern_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic i_en,
    output logic      o_bit
);
    logic [6:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
    end

    assign o_bit = r_lfsr[6];
endmodule
`endif

`default_nettype wire

// File: rtl/pattern_stream_gen.sv
// ============================================================================
// pattern_stream_gen : emits num_frames copies of 001101 separated by gap
//                      filler bits over a valid/ready serial stream.
//                      Filler is constant 1 unless PATTERN_GEN_LFSR_FILLER_EN
//                      selects the pattern_lfsr source.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module pattern_stream_gen
    import pattern_pkg::*;
#(
    parameter int FRAMES_W = 8,
    parameter int GAP_W    = 4
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    pattern_stream_gen_if.slave     bus
);
    state_e              r_state;
    state_e              w_state_nxt;
    logic [2:0]          r_idx;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [FRAMES_W-1:0] r_frames;
    logic [GAP_W-1:0]    r_gap;
    logic [FRAMES_W-1:0] r_sent;

    logic w_valid;
    logic w_xfer;
    logic w_pat_end;
    logic w_gap_end;
    logic w_last_frame;
    logic w_filler;

    assign w_valid      = (r_state == ST_PAT) || (r_state == ST_GAP);
    assign w_xfer       = w_valid && bus.ready_i;
    assign w_pat_end    = (r_idx == 3'(PAT_LEN - 1));
    assign w_gap_end    = (r_gap_cnt == (r_gap - GAP_W'(1)));
    // Evaluated before the increment, so the pattern now finishing is the last.
    assign w_last_frame = ((r_sent + FRAMES_W'(1)) == r_frames);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = (bus.num_frames_i == '0) ? ST_FIN : ST_PAT;
                end
            end
            ST_PAT: begin
                if (w_xfer && w_pat_end) begin
                    if (w_last_frame)       w_state_nxt = ST_FIN;
                    else if (r_gap != '0)   w_state_nxt = ST_GAP;
                    else                    w_state_nxt = ST_PAT;
                end
            end
            ST_GAP: begin
                if (w_xfer && w_gap_end) begin
                    w_state_nxt = ST_PAT;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_frames  <= '0;
            r_gap     <= '0;
            r_sent    <= '0;
        end else if ((r_state == ST_IDLE) && bus.start_i) begin
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_frames  <= bus.num_frames_i;
            r_gap     <= bus.gap_i;
            r_sent    <= '0;
        end else if ((r_state == ST_PAT) && w_xfer) begin
            if (w_pat_end) begin
                r_idx  <= '0;
                r_sent <= r_sent + FRAMES_W'(1);
            end else begin
                r_idx  <= r_idx + 3'd1;
            end
        end else if ((r_state == ST_GAP) && w_xfer) begin
            r_gap_cnt <= w_gap_end ? '0 : (r_gap_cnt + GAP_W'(1));
        end
    end

`ifdef PATTERN_GEN_LFSR_FILLER_EN
    pattern_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_en   ((r_state == ST_GAP) && w_xfer),
        .o_bit  (w_filler)
    );
`else
    assign w_filler = C;
`endif

    assign bus.valid_o      = w_valid;
    assign bus.data_o       = (r_state == ST_PAT) ? pat_bit(r_idx) :
                              (r_state == ST_GAP) ? w_filler       : B;
    assign bus.busy_o       = (r_state != ST_IDLE);
    assign bus.done_o       = (r_state == ST_FIN);
    assign bus.sent_count_o = r_sent;

endmodule

`default_nettype wire

// File: doc/pattern_stream_gen.md
PATTERN_STREAM_GEN -- requirements
Module: pattern_stream_gen

Interface
REQ-001 The module SHALL have the parameter FRAMES_W, default 8, which sets the width of the frame count.
REQ-002 The module SHALL have the parameter GAP_W, default 4, which sets the width of the filler-gap length.
REQ-003 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 start_i  input  1  single-cycle request to begin a burst; sampled only while idle.
REQ-006 num_frames_i  input  FRAMES_W  number of pattern insertions in the burst; latched on an accepted start.
REQ-007 gap_i  input  GAP_W  number of filler bits after each pattern; latched on an accepted start.
REQ-008 ready_i  input  1  downstream acceptance of the current bit.
REQ-009 valid_o  output  1  data_o carries a stream bit.
REQ-010 data_o  output  1  serial stream bit, where B=0 and C=1.
REQ-011 busy_o  output  1  a burst is in progress.
REQ-012 done_o  output  1  one-cycle pulse marking the end of a burst.
REQ-013 sent_count_o  output  FRAMES_W  number of complete patterns transferred in the current or last burst.

Function
REQ-014 The pattern SHALL be BBCCBC, which is 6'b001101, transmitted MSB first: 0,0,1,1,0,1.
REQ-015 The FSM SHALL be one-hot, with the states IDLE, PAT, GAP and FIN.
REQ-016 In IDLE, a start_i=1 at clock edge N SHALL latch the inputs, clear sent_count_o, and set busy_o=1 from edge N.
REQ-017 After a start at edge N with num_frames_i>0, the FSM SHALL enter PAT at edge N, and valid_o=1 with the first pattern bit SHALL be presented in the cycle after edge N.
REQ-018 When num_frames_i=0, the FSM SHALL go IDLE->FIN with no valid bits, and done_o SHALL pulse in the next cycle.
REQ-019 A bit SHALL transfer only on a clock edge where valid_o=1 and ready_i=1.
REQ-020 While valid_o=1 and ready_i=0, data_o and the FSM state SHALL hold unchanged.
REQ-021 In PAT, a 3-bit index SHALL count 0..5; the transfer of index 5 SHALL increment sent_count_o.
REQ-022 After the transfer of index 5, the FSM SHALL go to GAP if gap_i>0, otherwise directly to the next PAT.
REQ-023 The FSM SHALL go to FIN instead of GAP or PAT when the frame just sent was the last one.
REQ-024 In GAP, gap_i filler bits SHALL be sent with valid_o=1, and then the FSM SHALL return to PAT.
REQ-025 Default filler bits SHALL be constant 1, which guarantees that the stream contains exactly num_frames_i non-overlapping occurrences of 001101.
REQ-026 Back-to-back patterns (gap_i=0) SHALL still be counted as distinct occurrences.
REQ-027 FIN SHALL last one cycle with valid_o=0, done_o=1 and busy_o=1, then go to IDLE.
REQ-028 In FIN, the final sent_count_o SHALL be held until the next accepted start.
REQ-029 start_i SHALL be ignored when busy_o=1.
REQ-030 valid_o SHALL be 0 in IDLE and FIN.
REQ-031 data_o SHALL be 0 whenever valid_o=0.

Reset
REQ-032 Asserting rst_ni=0 SHALL immediately force the FSM to IDLE, regardless of clock.
REQ-033 While rst_ni=0, valid_o, data_o, busy_o, done_o and sent_count_o SHALL all be 0, and the indices and latched inputs SHALL be 0.
REQ-034 A reset during a burst SHALL abort the burst with no done_o pulse; the bits already transferred stand.
REQ-035 The first start SHALL be accepted on the first rising edge after rst_ni deasserts.

Configuration
REQ-036 The macro PATTERN_GEN_LFSR_FILLER_EN SHALL select the filler source.
REQ-037 With PATTERN_GEN_LFSR_FILLER_EN defined, filler bits SHALL come from a 7-bit maximal LFSR (x^7+x^6+1), seeded to 7'h5A on reset, advancing only on GAP transfers; the detector count is then >= num_frames_i.
REQ-038 Without PATTERN_GEN_LFSR_FILLER_EN, filler bits SHALL be constant 1 and no LFSR logic SHALL exist.

Structure
REQ-039 The shared package pattern_pkg SHALL hold PATTERN (6'b001101), PAT_LEN (6), B/C, the one-hot state constants and LFSR_SEED.
REQ-040 The one sub-module SHALL be pattern_lfsr (7-bit, enable input, seed from the package), instantiated only under the macro.

Verification
REQ-041 Bench: num_frames_i=1, gap_i=0, ready_i=1 -> 6 valid cycles carrying 0,0,1,1,0,1; done_o in cycle 7; sent_count_o=1.
REQ-042 Bench: num_frames_i=3, gap_i=2, ready_i=1 -> 001101 11 001101 11 001101 (22 valid bits); done_o once; sent_count_o=3.
REQ-043 Bench: num_frames_i=2, gap_i=0, with ready_i toggling 1,0 every cycle -> data held while ready_i=0; 12 transfers; bit order unchanged.
REQ-044 Bench: num_frames_i=0 -> no valid_o; done_o one cycle after start; sent_count_o=0.
REQ-045 Bench: start with num_frames_i=50, then rst_ni=0 after 20 transfers -> all outputs 0 immediately; no done_o; a new start after release works.
REQ-046 Bench: stream fed into the team's moore_nonover detector with num_frames_i=100, gap_i=3 -> 100 detector pulses counted (macro undefined).
